// File: rtl/rr_arb4way16.sv
// -----------------------------------------------------------------------------
// rr_arb4way16
//
// Round-robin arbiter and capture stage in front of Mux4way16. Four WIDTH-bit
// sources (A..D) request with VALID[i] and are accepted with READY[i]. One
// source wins per cycle. Its word and 2-bit index are registered and presented
// downstream as OUT/SEL with an OUT_VALID/OUT_READY handshake. SEL uses the
// Mux4way16 select encoding: 0=A, 1=B, 2=C, 3=D.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   asynchronous, active-high reset
//   A,B,C,D    in   source data, WIDTH bits each
//   VALID      in   per-source request (bit0=A .. bit3=D)
//   READY      out  per-source accept, one-hot or zero, combinational
//   OUT        out  registered winning word
//   SEL        out  registered index of the word held in OUT
//   OUT_VALID  out  OUT/SEL hold an unconsumed word
//   OUT_READY  in   downstream takes OUT this cycle
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, fixed priority A>B>C>D replaces the
//                      round-robin scan. Handshake, latency and reset
//                      behaviour do not change.
// -----------------------------------------------------------------------------
module rr_arb4way16 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [3:0]       VALID,
    output logic [3:0]       READY,
    output logic [WIDTH-1:0] OUT,
    output logic [1:0]       SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             out_valid_q;

    logic             load;
    logic             grant;
    logic [1:0]       winner;
    logic             found;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_data;

    // The output register can take a new word when it is empty or is being
    // drained this cycle. Draining and refilling together gives 1 word/cycle.
    assign load  = !out_valid_q || OUT_READY;
    assign grant = load && (VALID != 4'b0000);

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest set VALID bit wins. No pointer is kept.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = 2'(k);
            if (!found && VALID[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`else
    // Index of the most recent grant. Reset to 3 so the first scan is A,B,C,D.
    logic [1:0] last_q;

    // Round-robin: scan LAST+1, LAST+2, LAST+3, then LAST itself. The 2-bit
    // add wraps mod 4, so k=4 lands back on LAST.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && VALID[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        case (winner)
            2'd0:    win_data = A;
            2'd1:    win_data = B;
            2'd2:    win_data = C;
            default: win_data = D;
        endcase
    end

    // Reset empties the output register, which raises LOAD. READY is therefore
    // gated with RST so that no source sees an accept while reset is held.
    always_comb begin
        READY = 4'b0000;
        if (grant && !RST) begin
            READY[winner] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_q       <= '0;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            if (grant) begin
                out_q       <= win_data;
                sel_q       <= winner;
                out_valid_q <= 1'b1;
            end else begin
                // Drained with nothing to replace it: OUT and SEL keep their
                // last word, only the valid flag drops.
                out_valid_q <= 1'b0;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= 2'd3;
        end else if (grant) begin
            last_q <= winner;
        end
    end
`endif

    assign OUT       = out_q;
    assign SEL       = sel_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_rr_arb4way16.sv
// -----------------------------------------------------------------------------
// tb_rr_arb4way16
//
// Self-checking bench for rr_arb4way16. A behavioural model holds the expected
// output register and the index of the last grant. It picks winners by walking
// the sources in priority order with modulo-4 arithmetic. Directed scenarios
// run first, then randomized traffic. Define ARB_FIXED_PRIO_EN for both the
// bench and the RTL to check the fixed-priority build.
// -----------------------------------------------------------------------------
module tb_rr_arb4way16;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  src [4];
    logic [3:0]    valid;
    logic [3:0]    ready;
    logic [W-1:0]  out_w;
    logic [1:0]    sel;
    logic          out_valid;
    logic          out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int         m_out;
    int         m_sel;
    bit         m_vld;
    int         m_last;

    rr_arb4way16 #(.WIDTH(W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .A         (src[0]),
        .B         (src[1]),
        .C         (src[2]),
        .D         (src[3]),
        .VALID     (valid),
        .READY     (ready),
        .OUT       (out_w),
        .SEL       (sel),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_out  = 0;
        m_sel  = 0;
        m_vld  = 1'b0;
        m_last = 3;
    endfunction

    // Returns the winning source index, or -1 when no grant happens.
    function automatic int model_winner();
        int order;
        if (rst) return -1;
        if (m_vld && !out_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            order = k - 1;
`else
            order = (m_last + k) % 4;
`endif
            if (valid[order]) return order;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int w;
        w = model_winner();
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    // Advance one clock edge and update the model from the inputs that were
    // present at that edge. Returns to 1 time unit after the edge.
    task automatic tick();
        int  w;
        bit  ld;
        w  = model_winner();
        ld = !m_vld || out_ready;
        @(posedge clk);
        if (!rst && ld) begin
            if (w >= 0) begin
                m_out  = int'(src[w]);
                m_sel  = w;
                m_vld  = 1'b1;
                m_last = w;
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic r);
        valid     = v;
        out_ready = r;
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Fill the output register and hold it with backpressure.
        src[0] = 16'h0001; src[1] = 16'h0002; src[2] = 16'h0004; src[3] = 16'h0008;
        drive(4'b0001, 1'b0);
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_prefill: OUT_VALID=%0b expected 1", out_valid);
        end
        // Asynchronous reset between edges, with all sources requesting.
        drive(4'b1111, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if (out_w !== 16'h0000 || sel !== 2'b00 || out_valid !== 1'b0 || ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_async: OUT=%h SEL=%b OUT_VALID=%b READY=%b expected 0000 00 0 0000",
                     out_w, sel, out_valid, ready);
        end
        tick();
        tests_run++;
        if (ready !== 4'b0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_held: READY=%b OUT_VALID=%b expected 0000 0", ready, out_valid);
        end
        rst = 1'b0;
        drive(4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (out_w !== 16'h0000 || sel !== 2'b00 || out_valid !== 1'b0 || ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: OUT=%h SEL=%b OUT_VALID=%b READY=%b expected 0000 00 0 0000",
                         i, out_w, sel, out_valid, ready);
            end
        end
    endtask

    task automatic test_sweep();
        int exp_sel [5];
`ifdef ARB_FIXED_PRIO_EN
        exp_sel = '{0, 0, 0, 0, 0};
`else
        exp_sel = '{0, 1, 2, 3, 0};
`endif
        src[0] = 16'h0001; src[1] = 16'h0002; src[2] = 16'h0004; src[3] = 16'h0008;
        drive(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (ready !== 4'(1 << exp_sel[i])) begin
                tests_failed++;
                $display("FAIL sweep_ready[%0d]: READY=%b expected %b", i, ready, 4'(1 << exp_sel[i]));
            end
            tick();
            tests_run++;
            if (int'(sel) != exp_sel[i] || int'(out_w) != (1 << exp_sel[i]) || out_valid !== 1'b1
                || int'(sel) != m_sel || int'(out_w) != m_out) begin
                tests_failed++;
                $display("FAIL sweep[%0d]: SEL=%0d OUT=%h OUT_VALID=%b expected SEL=%0d OUT=%h OUT_VALID=1",
                         i, sel, out_w, out_valid, exp_sel[i], 16'(1 << exp_sel[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        // Empty the output register first.
        drive(4'b0000, 1'b1);
        tick();
        drive(4'b0010, 1'b0);
        tests_run++;
        if (ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_first_ready: READY=%b expected 0010", ready);
        end
        tick();
        tests_run++;
        if (out_w !== 16'h0002 || sel !== 2'b01 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_load: OUT=%h SEL=%b OUT_VALID=%b expected 0002 01 1", out_w, sel, out_valid);
        end
        held = out_w;
        src[1] = 16'h0022;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready[%0d]: READY=%b expected 0000", i, ready);
            end
            tick();
            tests_run++;
            if (out_w !== held || sel !== 2'b01 || out_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: OUT=%h SEL=%b OUT_VALID=%b expected %h 01 1",
                         i, out_w, sel, out_valid, held);
            end
        end
        drive(4'b0010, 1'b1);
        tests_run++;
        if (ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_release_ready: READY=%b expected 0010", ready);
        end
        tick();
        tests_run++;
        if (out_w !== 16'h0022 || sel !== 2'b01 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_refill: OUT=%h SEL=%b OUT_VALID=%b expected 0022 01 1", out_w, sel, out_valid);
        end
        src[1] = 16'h0002;
    endtask

    task automatic test_skip_wrap();
        // The last grant was B. With A and D requesting, D comes next, then A.
        src[0] = 16'h0001; src[3] = 16'h0008;
        drive(4'b1001, 1'b1);
        tests_run++;
        if (ready !== model_ready()) begin
            tests_failed++;
            $display("FAIL wrap_ready: READY=%b expected %b", ready, model_ready());
        end
        tick();
        tests_run++;
`ifdef ARB_FIXED_PRIO_EN
        if (sel !== 2'b00 || out_w !== 16'h0001) begin
            tests_failed++;
            $display("FAIL wrap_first: SEL=%b OUT=%h expected 00 0001", sel, out_w);
        end
`else
        if (sel !== 2'b11 || out_w !== 16'h0008) begin
            tests_failed++;
            $display("FAIL wrap_first: SEL=%b OUT=%h expected 11 0008", sel, out_w);
        end
`endif
        tick();
        tests_run++;
        if (sel !== 2'b00 || out_w !== 16'h0001 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_second: SEL=%b OUT=%h OUT_VALID=%b expected 00 0001 1", sel, out_w, out_valid);
        end
    endtask

    task automatic test_drain();
        src[0] = 16'h0001;
        drive(4'b0001, 1'b1);
        tick();
        drive(4'b0000, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || out_w !== 16'h0001) begin
            tests_failed++;
            $display("FAIL drain_full: OUT_VALID=%b OUT=%h expected 1 0001", out_valid, out_w);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || out_w !== 16'h0001 || sel !== 2'b00) begin
            tests_failed++;
            $display("FAIL drain_empty: OUT_VALID=%b OUT=%h SEL=%b expected 0 0001 00", out_valid, out_w, sel);
        end
    endtask

    task automatic test_random();
        int bad;
        int wait_cnt [4];
        bad = 0;
        for (int s = 0; s < 4; s++) wait_cnt[s] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 4; s++) src[s] = 16'($urandom);
            drive(4'($urandom), ($urandom_range(0, 3) != 0));
            tests_run++;
            if (ready !== model_ready()) begin
                tests_failed++;
                if (bad < 10) $display("FAIL rand_ready[%0d]: READY=%b expected %b", i, ready, model_ready());
                bad++;
            end
            // Count grants other sources received while each source waited.
            for (int s = 0; s < 4; s++) begin
                if (!valid[s] || ready[s]) wait_cnt[s] = 0;
                else if (ready != 4'b0000) wait_cnt[s]++;
            end
            tick();
            tests_run++;
            if (int'(out_w) != m_out || int'(sel) != m_sel || out_valid !== m_vld) begin
                tests_failed++;
                if (bad < 10) $display("FAIL rand_out[%0d]: OUT=%h SEL=%0d OUT_VALID=%b expected %h %0d %b",
                                       i, out_w, sel, out_valid, 16'(m_out), m_sel, m_vld);
                bad++;
            end
`ifndef ARB_FIXED_PRIO_EN
            for (int s = 0; s < 4; s++) begin
                tests_run++;
                if (wait_cnt[s] > 3) begin
                    tests_failed++;
                    if (bad < 10) $display("FAIL rand_fair[%0d]: source %0d waited %0d grants expected at most 3",
                                           i, s, wait_cnt[s]);
                    bad++;
                end
            end
`endif
        end
    endtask

    initial begin
        rst       = 1'b1;
        valid     = 4'b0000;
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) src[s] = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if (out_w !== 16'h0000 || sel !== 2'b00 || out_valid !== 1'b0 || ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_power_on: OUT=%h SEL=%b OUT_VALID=%b READY=%b expected 0000 00 0 0000",
                     out_w, sel, out_valid, ready);
        end
        rst = 1'b0;
        #1;

        test_reset();
        test_sweep();
        test_backpressure();
        test_skip_wrap();
        test_drain();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_arb4way16.md
Name: rr_arb4way16

Overview:
- Round-robin arbiter and capture stage that sits directly upstream of Mux4way16.
- Accepts four 16-bit request sources (A..D) under a per-source valid/ready handshake.
- Grants one source per cycle and registers the winning word plus its 2-bit index.
- Presents them downstream as OUT/SEL with a valid/ready handshake; SEL matches Mux4way16 select encoding (0=A, 1=B, 2=C, 3=D).

Parameters:
- WIDTH, 16, data width of A..D and OUT.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  reset, asynchronous, active-high.
- A  input  WIDTH  source 0 data.
- B  input  WIDTH  source 1 data.
- C  input  WIDTH  source 2 data.
- D  input  WIDTH  source 3 data.
- VALID  input  4  per-source request; bit i = source i (bit0=A .. bit3=D).
- READY  output  4  per-source accept, one-hot or zero; combinational.
- OUT  output  WIDTH  registered winning word.
- SEL  output  2  registered index of the source held in OUT.
- OUT_VALID  output  1  OUT/SEL hold an unconsumed word.
- OUT_READY  input  1  downstream accepts OUT this cycle.

Behaviour:
- Single clock domain CLK. RST asynchronous, active-high; no other reset.
- State:
  - out register: OUT, SEL, OUT_VALID.
  - 2-bit round-robin pointer LAST = index of the most recent grant.
- Reset values: OUT=0, SEL=0, OUT_VALID=0, LAST=3, so the first priority order is A,B,C,D.
- Load enable: LOAD = !OUT_VALID | OUT_READY. With OUT_VALID=1 and OUT_READY=1, drain and refill occur in the same cycle, so a full stream runs 1 word/cycle.
- Grant (combinational):
  - Active only when LOAD=1 and VALID!=0.
  - Winner = first i with VALID[i]=1, scanning LAST+1, LAST+2, LAST+3, LAST (mod 4 wrap).
  - READY[winner]=1; all other READY bits 0.
  - LOAD=0 or VALID=0 -> READY=0.
  - READY never depends on its own VALID bit combinationally beyond grant selection; no combinational path from OUT_READY to OUT.
- On the CLK edge with a grant: OUT<=data of winner, SEL<=winner, OUT_VALID<=1, LAST<=winner.
- On the CLK edge with LOAD=1 and no grant: OUT_VALID<=0; OUT, SEL and LAST hold.
- On the CLK edge with LOAD=0: everything holds. OUT and SEL must remain stable while OUT_VALID=1 and OUT_READY=0.
- Latency: a word accepted in cycle N is visible on OUT with OUT_VALID=1 in cycle N+1.
- Fairness:
  - A continuously requesting source waits at most 3 grants.
  - With all four VALID high and OUT_READY=1, grants are 0,1,2,3,0,...
- A source dropping VALID before its grant is legal; it is simply skipped.
- Sources must hold data stable while VALID=1 and READY=0; the block does not check this.
- RST asserted mid-transfer: immediate return to reset values. A word in OUT is discarded; READY drops to 0 combinationally while RST=1.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority A>B>C>D (lowest set VALID bit wins). LAST is not implemented or ignored. Starvation of lower sources is permitted.
- Undefined (default): round-robin as described under Behaviour.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
- Reset/idle: assert RST mid-simulation with OUT_VALID=1 -> OUT=0000, SEL=00, OUT_VALID=0, READY=0000 immediately. After release with VALID=0 -> outputs stay at reset values.
- Round-robin sweep: A=0001, B=0002, C=0004, D=0008, VALID=1111, OUT_READY=1 -> cycles after release show SEL=00,01,10,11,00 and OUT=0001,0002,0004,0008,0001, with OUT_VALID=1 each cycle.
- Backpressure: VALID=0010, OUT_READY=0 -> after 1 cycle OUT=0002, SEL=01, OUT_VALID=1. READY=0000 and OUT stable for 5 cycles. Raise OUT_READY -> READY=0010 that cycle and OUT refilled next cycle.
- Skip and wrap: LAST=1 (after a B grant), VALID=1001 -> D wins (SEL=11, OUT=0008); next grant A (SEL=00).
- Drain to empty: single A request then VALID=0000, OUT_READY=1 -> OUT_VALID high 1 cycle then 0; OUT holds 0001.
- ARB_FIXED_PRIO_EN build: VALID=1111, OUT_READY=1 -> SEL=00 every cycle for 8 cycles; READY=0001 throughout.
